// File: rtl/iterative_divider_if.sv
// Operand/result bundle between the control unit (master) and the
// iterative divider (slave).
interface iterative_divider_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic            flush;
  logic [1:0]      funct;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            reg_write;

  modport master (
    output start, flush, funct, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_out, reg_write
  );

  modport slave (
    input  start, flush, funct, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_out, reg_write
  );
endinterface

// File: rtl/iterative_divider.sv
// Restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with divide-by-zero and signed-overflow results resolved at accept time.
module iterative_divider #(
  parameter  int XLEN = 64,
  localparam int CNTW = $clog2(XLEN) + 1
) (
  input logic                 clk,
  input logic                 reset,
  iterative_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  state_t          w_nextState;
  logic [CNTW-1:0] r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_divisor;
  logic            r_negQ;
  logic            r_negR;
  logic            r_isRem;
  logic [4:0]      r_tag;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rdOut;

  logic            w_signedOp;
  logic            w_aNeg;
  logic            w_bNeg;
  logic [XLEN-1:0] w_absA;
  logic [XLEN-1:0] w_absB;
  logic            w_divZero;
  logic            w_overflow;
  logic            w_special;
  logic [XLEN-1:0] w_specialResult;
  logic            w_accept;
  logic            w_busy;
  logic            w_done;
  logic [XLEN:0]   w_shifted;
  logic [XLEN:0]   w_trial;
  logic            w_trialOk;
  logic [XLEN-1:0] w_fixResult;

  assign w_signedOp = ~bus.funct[0];
  assign w_aNeg     = w_signedOp & bus.rs1_data[XLEN-1];
  assign w_bNeg     = w_signedOp & bus.rs2_data[XLEN-1];
  assign w_absA     = w_aNeg ? -bus.rs1_data : bus.rs1_data;
  assign w_absB     = w_bNeg ? -bus.rs2_data : bus.rs2_data;
  assign w_divZero  = (bus.rs2_data == '0);
  assign w_overflow = w_signedOp && (bus.rs1_data == MOST_NEG) && (bus.rs2_data == '1);
  assign w_special  = w_divZero | w_overflow;

  // Divide-by-zero wins over overflow; for REM both cases return what RISC-V mandates.
  assign w_specialResult = w_divZero ? (bus.funct[1] ? bus.rs1_data : '1)
                                     : (bus.funct[1] ? '0 : bus.rs1_data);

  assign w_accept = bus.start && !bus.flush && (r_state == S_IDLE || r_state == S_DONE);

  // The shifted partial remainder needs one extra bit; the trial's MSB is its sign.
  assign w_shifted = {r_rem, r_quo[XLEN-1]};
  assign w_trial   = w_shifted - {1'b0, r_divisor};
  assign w_trialOk = ~w_trial[XLEN];

  assign w_fixResult = r_isRem ? (r_negR ? -r_rem : r_rem)
                               : (r_negQ ? -r_quo : r_quo);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_nextState = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (bus.flush)                         w_nextState = S_IDLE;
        else if (r_cnt == CNTW'(XLEN - 1))     w_nextState = S_FIX;
      end
      S_FIX: begin
        w_busy      = 1'b1;
        w_nextState = bus.flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (w_accept) w_nextState = w_special ? S_DONE : S_CALC;
        else          w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // rd_out only moves on completion so a flushed operation leaves it untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_isRem   <= 1'b0;
      r_tag     <= '0;
      r_result  <= '0;
      r_rdOut   <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= w_absA;
      r_divisor <= w_absB;
      r_negQ    <= w_aNeg ^ w_bNeg;
      r_negR    <= w_aNeg;
      r_isRem   <= bus.funct[1];
      r_tag     <= bus.rd_in;
      if (w_special) begin
        r_result <= w_specialResult;
        r_rdOut  <= bus.rd_in;
      end
    end else if (r_state == S_CALC && !bus.flush) begin
      r_rem <= w_trialOk ? w_trial[XLEN-1:0] : w_shifted[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_trialOk};
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == S_FIX && !bus.flush) begin
      r_result <= w_fixResult;
      r_rdOut  <= r_tag;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.result    = r_result;
  assign bus.rd_out    = r_rdOut;
  assign bus.reg_write = w_done && (r_rdOut != 5'd0);

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: a cycle-level reference model
// built on plain SV arithmetic, directed cases, and randomized operations.
module tb_iterative_divider;

  localparam int          XLEN = 64;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  iterative_divider_if #(.XLEN(XLEN)) bus ();

  iterative_divider #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  // Reference model state: cycles of busy remaining and the pending/visible result.
  int         mBusyLeft = 0;
  logic [63:0] mPendRes = '0;
  logic [4:0]  mPendRd  = '0;
  logic [63:0] mLastRes = '0;
  logic [4:0]  mLastRd  = '0;
  logic        mExpDone = 1'b0;
  bit          modelValid = 1'b0;

  function automatic logic [63:0] refResult(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    longint sa = a;
    longint sb = b;
    case (f)
      2'b00:   return (b == 0) ? '1 : ((a == MIN && b == '1) ? a : 64'(sa / sb));
      2'b01:   return (b == 0) ? '1 : a / b;
      2'b10:   return (b == 0) ? a  : ((a == MIN && b == '1) ? 64'd0 : 64'(sa % sb));
      default: return (b == 0) ? a  : a % b;
    endcase
  endfunction

  function automatic bit isSpecial(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    return (b == 0) || (!f[0] && a == MIN && b == '1);
  endfunction

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return '1;
      3:       return MIN;
      4:       return 64'($urandom_range(0, 1000));
      5:       return -(64'($urandom_range(1, 1000)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives a one-cycle start; must be called at a falling edge.
  task automatic applyStimulus(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    bus.start    = 1'b1;
    bus.funct    = f;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input int maxEdges, output int edges);
    edges = 0;
    while (!bus.done && edges < maxEdges) begin
      @(negedge clk);
      edges++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitDone timeout: got no done after %0d cycles, expected done", edges);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      mBusyLeft = 0;
      mLastRes  = '0;
      mLastRd   = '0;
      mExpDone  = 1'b0;
    end else begin
      mExpDone = 1'b0;
      if (mBusyLeft > 0) begin
        if (bus.flush) begin
          mBusyLeft = 0;
        end else begin
          mBusyLeft--;
          if (mBusyLeft == 0) begin
            mExpDone = 1'b1;
            mLastRes = mPendRes;
            mLastRd  = mPendRd;
          end
        end
      end else if (bus.start && !bus.flush) begin
        if (isSpecial(bus.funct, bus.rs1_data, bus.rs2_data)) begin
          mExpDone = 1'b1;
          mLastRes = refResult(bus.funct, bus.rs1_data, bus.rs2_data);
          mLastRd  = bus.rd_in;
        end else begin
          mBusyLeft = XLEN + 1;
          mPendRes  = refResult(bus.funct, bus.rs1_data, bus.rs2_data);
          mPendRd   = bus.rd_in;
        end
      end
    end
    modelValid = 1'b1;
  end

  always @(negedge clk) begin
    if (modelValid) begin
      if (bus.done === 1'b1) doneCount++;
      checkOutput("busy",      64'(bus.busy),      64'(mBusyLeft > 0));
      checkOutput("done",      64'(bus.done),      64'(mExpDone));
      checkOutput("result",    bus.result,         mLastRes);
      checkOutput("rd_out",    64'(bus.rd_out),    64'(mLastRd));
      checkOutput("reg_write", 64'(bus.reg_write), 64'(mExpDone && mLastRd != 0));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int k;
    int flushAt;
    int doneBefore;
    bit doFlush;
    logic [1:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;

    bus.start    = 1'b1;
    bus.flush    = 1'b0;
    bus.funct    = 2'b01;
    bus.rs1_data = 64'd100;
    bus.rs2_data = 64'd7;
    bus.rd_in    = 5'd5;
    reset        = 1'b0;

    checkOutput("model DIVU 100/7", refResult(2'b01, 64'd100, 64'd7), 64'd14);
    checkOutput("model DIV -7/2",   refResult(2'b00, -64'sd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("model REM -7/2",   refResult(2'b10, -64'sd7, 64'd2), '1);
    checkOutput("model DIV MIN/-1", refResult(2'b00, MIN, '1), MIN);

    repeat (2) @(negedge clk);
    checkOutput("reset busy",   64'(bus.busy),   64'd0);
    checkOutput("reset done",   64'(bus.done),   64'd0);
    checkOutput("reset result", bus.result,      64'd0);
    checkOutput("reset rd_out", 64'(bus.rd_out), 64'd0);
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idle after reset", 64'(bus.busy), 64'd0);

    applyStimulus(2'b01, 64'd100, 64'd7, 5'd5);
    waitDone(100, lat);
    checkOutput("DIVU latency",   64'(lat),           64'(XLEN + 1));
    checkOutput("DIVU result",    bus.result,         64'd14);
    checkOutput("DIVU rd_out",    64'(bus.rd_out),    64'd5);
    checkOutput("DIVU reg_write", 64'(bus.reg_write), 64'd1);
    @(negedge clk);
    checkOutput("done one cycle", 64'(bus.done), 64'd0);

    applyStimulus(2'b11, 64'd100, 64'd7, 5'd5);
    waitDone(100, lat);
    checkOutput("REMU result", bus.result, 64'd2);

    applyStimulus(2'b00, -64'sd7, 64'd2, 5'd1);
    waitDone(100, lat);
    checkOutput("DIV -7/2", bus.result, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(2'b10, -64'sd7, 64'd2, 5'd2);
    waitDone(100, lat);
    checkOutput("REM -7/2", bus.result, '1);
    applyStimulus(2'b00, 64'd7, -64'sd2, 5'd0);
    waitDone(100, lat);
    checkOutput("DIV 7/-2",        bus.result,         64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("rd0 done",        64'(bus.done),      64'd1);
    checkOutput("rd0 reg_write",   64'(bus.reg_write), 64'd0);

    applyStimulus(2'b00, 64'd42, 64'd0, 5'd3);
    waitDone(5, lat);
    checkOutput("DIV /0 latency", 64'(lat), 64'd0);
    checkOutput("DIV /0 result",  bus.result, '1);
    checkOutput("DIV /0 busy",    64'(bus.busy), 64'd0);
    applyStimulus(2'b11, 64'd42, 64'd0, 5'd3);
    waitDone(5, lat);
    checkOutput("REMU /0 result", bus.result, 64'd42);
    applyStimulus(2'b00, MIN, '1, 5'd4);
    waitDone(5, lat);
    checkOutput("DIV ovf latency", 64'(lat), 64'd0);
    checkOutput("DIV ovf result",  bus.result, MIN);
    applyStimulus(2'b10, MIN, '1, 5'd4);
    waitDone(5, lat);
    checkOutput("REM ovf result", bus.result, 64'd0);

    @(negedge clk);
    applyStimulus(2'b01, 64'd1000, 64'd10, 5'd3);
    repeat (9) @(negedge clk);
    applyStimulus(2'b01, 64'd5, 64'd5, 5'd4);
    waitDone(100, lat);
    checkOutput("ignored start result", bus.result,      64'd100);
    checkOutput("ignored start rd_out", 64'(bus.rd_out), 64'd3);
    applyStimulus(2'b11, 64'd1000, 64'd7, 5'd6);
    waitDone(100, lat);
    checkOutput("back-to-back latency", 64'(lat),   64'(XLEN + 1));
    checkOutput("back-to-back result",  bus.result, 64'd6);

    @(negedge clk);
    applyStimulus(2'b01, 64'd100, 64'd7, 5'd9);
    waitDone(100, lat);
    @(negedge clk);
    doneBefore = doneCount;
    applyStimulus(2'b01, 64'd1000, 64'd3, 5'd12);
    repeat (29) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush busy", 64'(bus.busy), 64'd0);
    repeat (80) @(negedge clk);
    checkOutput("flush no done",  64'(doneCount - doneBefore), 64'd0);
    checkOutput("flush result",   bus.result,      64'd14);
    checkOutput("flush rd_out",   64'(bus.rd_out), 64'd9);

    doneBefore = doneCount;
    applyStimulus(2'b00, 64'd12345, 64'd17, 5'd7);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("mid reset busy",   64'(bus.busy),   64'd0);
    checkOutput("mid reset result", bus.result,      64'd0);
    checkOutput("mid reset rd_out", 64'(bus.rd_out), 64'd0);
    repeat (80) @(negedge clk);
    checkOutput("mid reset no done", 64'(doneCount - doneBefore), 64'd0);

    for (int i = 0; i < 150; i++) begin
      f       = 2'($urandom_range(0, 3));
      a       = randOperand();
      b       = randOperand();
      rd      = 5'($urandom_range(0, 31));
      doFlush = ($urandom_range(0, 7) == 0);
      flushAt = $urandom_range(0, 70);
      applyStimulus(f, a, b, rd);
      k = 0;
      while (k < 100 && !bus.done && bus.busy) begin
        if (doFlush && k == flushAt) bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        k++;
      end
      if (k >= 100) begin
        checks++;
        errors++;
        $display("[TB] FAIL random op %0d: got busy after %0d cycles, expected completion", i, k);
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
